// File: rtl/subbytes_sched_if.sv
// Request/response bundle between the two SubBytes requesters (cipher state
// and key expansion) and the shared subword scheduler.
interface subbytes_sched_if;
   logic         st_req;
   logic [127:0] st_in;
   logic         st_done;
   logic [127:0] st_out;
   logic         key_req;
   logic [31:0]  key_in;
   logic         key_done;
   logic [31:0]  key_out;
   logic         busy;

   modport master (
      output st_req, st_in, key_req, key_in,
      input  st_done, st_out, key_done, key_out, busy
   );

   modport slave (
      input  st_req, st_in, key_req, key_in,
      output st_done, st_out, key_done, key_out, busy
   );
endinterface

// File: rtl/subbytes_sched.sv
// Shares one 4-byte AES subword unit between a 128-bit state SubBytes (4 beats)
// and a 32-bit key SubWord (1 beat). Define SUBBYTES_SCHED_KEYPRI_EN for fixed key priority.

module subbytes_sched_subword (
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = '0;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Multiplicative inverse as b^254, followed by the AES affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] p2, p4, p8, p16, p32, p64, p128, inv;
      p2   = gf_mul(b, b);
      p4   = gf_mul(p2, p2);
      p8   = gf_mul(p4, p4);
      p16  = gf_mul(p8, p8);
      p32  = gf_mul(p16, p16);
      p64  = gf_mul(p32, p32);
      p128 = gf_mul(p64, p64);
      inv  = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                    gf_mul(gf_mul(p32, p64), p128));
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   for (genvar i = 0; i < 4; i++) begin : g_byte
      assign word_o[8*i +: 8] = sbox(word_i[8*i +: 8]);
   end
endmodule

// state   | meaning
// IDLE    | waiting; arbitrates between eligible requests
// ST_RUN  | substituting buffered state word[cnt], MS word first; commits on cnt = 3
// KEY_RUN | substituting buffered key word; commits on the next edge
module subbytes_sched (
   input  logic            clk,
   input  logic            reset,
   subbytes_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ST_RUN, KEY_RUN} state_t;

   state_t        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [127:0]  st_buf_q, st_buf_d;
   logic [31:0]   key_buf_q, key_buf_d;
   logic [95:0]   res_q, res_d;
   logic [127:0]  st_out_q, st_out_d;
   logic [31:0]   key_out_q, key_out_d;
   logic          st_done_q, st_done_d;
   logic          key_done_q, key_done_d;
   logic          st_elig, key_elig, grant_st, grant_key;
   logic [31:0]   sub_in, sub_out;

   subbytes_sched_subword u_subword (.word_i(sub_in), .word_o(sub_out));

   // A requester is deaf in the cycle its own done is showing.
   assign st_elig  = bus.st_req  & ~st_done_q;
   assign key_elig = bus.key_req & ~key_done_q;

`ifdef SUBBYTES_SCHED_KEYPRI_EN
   assign grant_key = key_elig;
   assign grant_st  = st_elig & ~key_elig;
`else
   logic last_key_q, last_key_d;

   assign grant_st  = st_elig  & (~key_elig | last_key_q);
   assign grant_key = key_elig & (~st_elig  | ~last_key_q);

   always_comb begin
      last_key_d = last_key_q;
      if (state_q == IDLE) begin
         if (grant_st)       last_key_d = 1'b0;
         else if (grant_key) last_key_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_key_q <= 1'b1;
      else       last_key_q <= last_key_d;
   end
`endif

   always_comb begin
      sub_in = key_buf_q;
      if (state_q == ST_RUN) begin
         case (cnt_q)
            2'd0:    sub_in = st_buf_q[127:96];
            2'd1:    sub_in = st_buf_q[95:64];
            2'd2:    sub_in = st_buf_q[63:32];
            default: sub_in = st_buf_q[31:0];
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      st_buf_d   = st_buf_q;
      key_buf_d  = key_buf_q;
      res_d      = res_q;
      st_out_d   = st_out_q;
      key_out_d  = key_out_q;
      st_done_d  = 1'b0;
      key_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_st) begin
               st_buf_d = bus.st_in;
               cnt_d    = 2'd0;
               state_d  = ST_RUN;
            end else if (grant_key) begin
               key_buf_d = bus.key_in;
               state_d   = KEY_RUN;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
               2'd0: res_d[95:64] = sub_out;
               2'd1: res_d[63:32] = sub_out;
               2'd2: res_d[31:0]  = sub_out;
               default: begin
                  st_out_d  = {res_q, sub_out};
                  st_done_d = 1'b1;
                  state_d   = IDLE;
               end
            endcase
         end
         KEY_RUN: begin
            key_out_d  = sub_out;
            key_done_d = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         st_buf_q   <= '0;
         key_buf_q  <= '0;
         res_q      <= '0;
         st_out_q   <= '0;
         key_out_q  <= '0;
         st_done_q  <= 1'b0;
         key_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         st_buf_q   <= st_buf_d;
         key_buf_q  <= key_buf_d;
         res_q      <= res_d;
         st_out_q   <= st_out_d;
         key_out_q  <= key_out_d;
         st_done_q  <= st_done_d;
         key_done_q <= key_done_d;
      end
   end

   assign bus.st_out   = st_out_q;
   assign bus.st_done  = st_done_q;
   assign bus.key_out  = key_out_q;
   assign bus.key_done = key_done_q;
   assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_subbytes_sched.sv
// Bench for subbytes_sched: transaction-level reference model checked every
// cycle, plus directed scenarios with literal results and latencies.
module tb_subbytes_sched;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   subbytes_sched_if bus_if();
   subbytes_sched dut (.clk(clk), .reset(reset), .bus(bus_if));

   always #5 clk = ~clk;

   // Reference arithmetic: polynomial product reduced mod x^8+x^4+x^3+x+1,
   // inverse found by search, affine transform written bit by bit.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      logic [14:0] poly;
      p = '0;
      poly = 15'h011b;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({7'd0, a} << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (poly << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] sb(input logic [7:0] x);
      logic [7:0] inv, c, r;
      inv = 8'h00;
      c   = 8'h63;
      for (int y = 1; y < 256; y++) if (gmul(x, y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
         r[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      return r;
   endfunction

   function automatic logic [31:0] m_sub32(input logic [31:0] w);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sb(w[8*i +: 8]);
      return r;
   endfunction

   function automatic logic [127:0] m_sub128(input logic [127:0] d);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sb(d[8*i +: 8]);
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: service time remaining, what is in service, and the published results.
   int           m_left;
   logic         m_kind_key, m_last_key;
   logic [127:0] m_st, m_st_out;
   logic [31:0]  m_key, m_key_out;
   logic         m_st_done, m_key_done;
   logic         st_ok, key_ok, take_key;

   assign st_ok  = bus_if.st_req  && !m_st_done;
   assign key_ok = bus_if.key_req && !m_key_done;
`ifdef SUBBYTES_SCHED_KEYPRI_EN
   assign take_key = key_ok;
`else
   assign take_key = key_ok && (!st_ok || !m_last_key);
`endif

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_left <= 0; m_kind_key <= 1'b0; m_last_key <= 1'b1;
         m_st <= '0; m_key <= '0; m_st_out <= '0; m_key_out <= '0;
         m_st_done <= 1'b0; m_key_done <= 1'b0;
      end else begin
         m_st_done  <= 1'b0;
         m_key_done <= 1'b0;
         if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               if (m_kind_key) begin m_key_out <= m_sub32(m_key);  m_key_done <= 1'b1; end
               else            begin m_st_out  <= m_sub128(m_st);  m_st_done  <= 1'b1; end
            end
         end else if (take_key) begin
            m_kind_key <= 1'b1; m_key <= bus_if.key_in; m_left <= 1; m_last_key <= 1'b1;
         end else if (st_ok) begin
            m_kind_key <= 1'b0; m_st <= bus_if.st_in; m_left <= 4; m_last_key <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("st_out",   bus_if.st_out,   m_st_out);
      chk("key_out",  {96'd0, bus_if.key_out}, {96'd0, m_key_out});
      chk("st_done",  {127'd0, bus_if.st_done},  {127'd0, m_st_done});
      chk("key_done", {127'd0, bus_if.key_done}, {127'd0, m_key_done});
      chk("busy",     {127'd0, bus_if.busy},     {127'd0, (m_left > 0)});
   end

   // Requester behaviour: hold req until done is seen, then drop it.
   task automatic do_st(input logic [127:0] d, output int lat);
      bus_if.st_in = d; bus_if.st_req = 1'b1; lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus_if.st_done) begin lat = n; break; end
      end
      bus_if.st_req = 1'b0;
      if (lat < 0) begin n_cmp++; n_err++; $display("FAIL st_timeout: got no st_done expected done within 40 cycles"); end
   endtask

   task automatic do_key(input logic [31:0] k, output int lat);
      bus_if.key_in = k; bus_if.key_req = 1'b1; lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus_if.key_done) begin lat = n; break; end
      end
      bus_if.key_req = 1'b0;
      if (lat < 0) begin n_cmp++; n_err++; $display("FAIL key_timeout: got no key_done expected done within 40 cycles"); end
   endtask

   logic [127:0] vec_st  [4] = '{128'h00112233_44556677_8899aabb_ccddeeff,
                                 128'h3243f6a8_885a308d_313198a2_e0370734,
                                 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a,
                                 128'h01020304_05060708_090a0b0c_0d0e0f10};
   logic [31:0]  vec_key [4] = '{32'h09cf4f3c, 32'h2b7e1516, 32'hdeadbeef, 32'h00000001};
   int           vec_off [4] = '{0, 1, 3, 0};

   initial begin
      int ls, lk;
      bus_if.st_req = 1'b0; bus_if.key_req = 1'b0;
      bus_if.st_in = '0; bus_if.key_in = '0;

      chk("model_sb_00", {120'd0, sb(8'h00)}, {120'd0, 8'h63});
      chk("model_sb_53", {120'd0, sb(8'h53)}, {120'd0, 8'hed});
      chk("model_sb_ff", {120'd0, sb(8'hff)}, {120'd0, 8'h16});
      chk("model_sub32", {96'd0, m_sub32(32'h00010253)}, {96'd0, 32'h637c77ed});

      repeat (3) @(negedge clk);
      chk("rst_st_out", bus_if.st_out, 128'd0);
      chk("rst_busy", {127'd0, bus_if.busy}, 128'd0);
      reset = 1'b0;

      // Simultaneous first requests after reset.
      fork
         do_st(128'h00010203_04050607_08090a0b_0c0d0e0f, ls);
         do_key(32'h00010253, lk);
      join
`ifdef SUBBYTES_SCHED_KEYPRI_EN
      chk("tie_st_lat", 128'(ls), 128'd7);
      chk("tie_key_lat", 128'(lk), 128'd2);
`else
      chk("tie_st_lat", 128'(ls), 128'd5);
      chk("tie_key_lat", 128'(lk), 128'd7);
`endif
      @(negedge clk);

      do_st(128'd0, ls);
      chk("zero_st_lat", 128'(ls), 128'd5);
      chk("zero_st_out", bus_if.st_out, {16{8'h63}});
      @(negedge clk);

      do_key(32'h00010253, lk);
      chk("key_lat", 128'(lk), 128'd2);
      chk("key_out", {96'd0, bus_if.key_out}, {96'd0, 32'h637c77ed});
      chk("key_keeps_st_out", bus_if.st_out, {16{8'h63}});
      @(negedge clk);

      do_st(128'h53000000_00000000_00000000_000000ff, ls);
      chk("edge_st_out", bus_if.st_out, 128'hed636363_63636363_63636363_63636316);
      @(negedge clk);

      // Key held while a state operation runs.
      fork
         do_st(128'hcafef00d_12345678_9abcdef0_0fedcba9, ls);
         begin @(negedge clk); do_key(32'h52525252, lk); end
      join
      chk("held_st_lat", 128'(ls), 128'd5);
      chk("held_key_lat", 128'(lk), 128'd6);
      chk("held_key_out", {96'd0, bus_if.key_out}, {96'd0, 32'h00000000});
      @(negedge clk);

      // Reset while ST_RUN sits at cnt = 2, then re-issue.
      bus_if.st_in = 128'h53000000_00000000_00000000_000000ff;
      bus_if.st_req = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_st_out", bus_if.st_out, 128'd0);
      chk("abort_key_out", {96'd0, bus_if.key_out}, 128'd0);
      chk("abort_busy", {127'd0, bus_if.busy}, 128'd0);
      chk("abort_st_done", {127'd0, bus_if.st_done}, 128'd0);
      @(negedge clk);
      reset = 1'b0;
      do_st(128'h53000000_00000000_00000000_000000ff, ls);
      chk("reissue_lat", 128'(ls), 128'd5);
      chk("reissue_out", bus_if.st_out, 128'hed636363_63636363_63636363_63636316);
      @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         fork
            do_st(vec_st[v], ls);
            begin repeat (vec_off[v]) @(negedge clk); do_key(vec_key[v], lk); end
         join
         @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/subbytes_sched.md
SUBBYTES_SCHED -- requirements
Module: subbytes_sched

Interface
REQ-001 SHALL have no parameters; the state width is fixed at 128 bits and the word width at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 st_req  input  1  level request from the cipher datapath for a full 128-bit SubBytes.
REQ-005 st_in  input  128  cipher state; sampled only on the accepting edge.
REQ-006 st_done  output  1  one-cycle pulse: st_out is valid.
REQ-007 st_out  output  128  byte-substituted state; held until the next state completion.
REQ-008 key_req  input  1  level request from key expansion for one 32-bit SubWord.
REQ-009 key_in  input  32  key word; sampled only on the accepting edge.
REQ-010 key_done  output  1  one-cycle pulse: key_out is valid.
REQ-011 key_out  output  32  substituted key word; held until the next key completion.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL contain exactly one internal 32-bit subword instance (four sbox bytes) shared by both requesters.
REQ-014 SHALL implement the FSM states IDLE, ST_RUN and KEY_RUN.
REQ-015 Acceptance: in IDLE, on an edge with a granted request, SHALL latch the input and move to ST_RUN (beat counter = 0) or KEY_RUN.
REQ-016 ST_RUN: each edge SHALL write the subword result for buffered word[cnt] into the result register, most-significant word [127:96] first, then increment cnt.
REQ-017 ST_RUN: the edge with cnt = 3 SHALL commit st_out, assert st_done for the following cycle only, and return to IDLE.
REQ-018 KEY_RUN: the next edge SHALL commit key_out, assert key_done for the following cycle only, and return to IDLE.
REQ-019 Latency from the accepting edge E0: st_done is high after edge E4; key_done is high after edge E1.
REQ-020 Only one request is in service at a time; a request arriving while busy waits, held by its requester, until IDLE.
REQ-021 A request SHALL be ignored in any cycle in which its own done is high; the requester drops req on seeing done.
REQ-022 Default tie-break (both requests high in IDLE, both eligible) SHALL be round-robin: grant the requester not served last; the last-served flag updates on each acceptance.
REQ-023 Outputs SHALL be registered; st_out and key_out SHALL never change except on their own completion edge.
REQ-024 Requests sampled outside IDLE SHALL have no effect on FSM state or outputs.

Reset
REQ-025 Reset SHALL force: FSM = IDLE, cnt = 0, st_out = 0, key_out = 0, st_done = 0, key_done = 0, busy = 0, last-served = key (so the first tie grants state).
REQ-026 Reset mid-operation SHALL abort the operation, discard the partial result, and produce no done pulse; the requester re-requests afterwards.

Configuration
REQ-027 Macro SUBBYTES_SCHED_KEYPRI_EN defined: key_req SHALL win every tie (fixed priority), and the last-served flag is unused.
REQ-028 Macro SUBBYTES_SCHED_KEYPRI_EN undefined: round-robin arbitration per REQ-022.

Verification
REQ-029 st_in = 0 with st_req alone -> after E4, st_done = 1 for one cycle, st_out = 0x6363...63 (16 bytes); busy high for cycles E0..E4.
REQ-030 key_in = 0x00010253 with key_req alone -> after E1, key_done = 1, key_out = 0x637C77ED; st_out unchanged.
REQ-031 st_in = 0x53000000_00000000_00000000_000000FF -> st_out = 0xED636363_63636363_63636363_63636316.
REQ-032 st_req and key_req raised in the same IDLE cycle after reset, round-robin -> state served first (done after E4), key accepted in the next eligible IDLE cycle; with SUBBYTES_SCHED_KEYPRI_EN -> key served first.
REQ-033 Reset asserted at ST_RUN cnt = 2 -> all outputs 0, no st_done, FSM IDLE; the re-issued request completes normally.
REQ-034 key_req held continuously during a state operation -> key is not accepted until IDLE, then key_done follows two edges later; no request is lost or duplicated.
